// File: rtl/ext_pipe.sv
// Pipelined immediate extender: computes the extended operand, then buffers it in
// an output register backed by a single skid entry under valid/ready flow control.
module ext_pipe #(
    parameter int IMM_W  = 16,
    parameter int DATA_W = 32,
    parameter int SHIFT  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IMM_W-1:0]  imm,
    input  logic [2:0]        EOp,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] ext,
    output logic              bad_op
);

    if (DATA_W < IMM_W + SHIFT) begin : g_bad_params
        $error("ext_pipe: DATA_W must be >= IMM_W + SHIFT");
    end

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        TWO
    } state_t;

    state_t            state, state_n;
    logic [DATA_W-1:0] or_q, sk_q;
    logic [DATA_W-1:0] zx, sx, ext_new;
    logic              in_ready_q, bad_q;
    logic              accept, deliver, reserved;
    logic              load_or, load_sk, move_sk, bad_set;

    always_comb begin
        zx       = DATA_W'(imm);
        sx       = zx | ({DATA_W{imm[IMM_W-1]}} << IMM_W);
        reserved = EOp[2] & EOp[1];
        case (EOp)
            3'b000:  ext_new = sx;
            3'b001:  ext_new = zx;
            3'b010:  ext_new = zx << (DATA_W - IMM_W);
            3'b011:  ext_new = sx << SHIFT;
            3'b100:  ext_new = zx << SHIFT;
            3'b101:  ext_new = zx | ({DATA_W{1'b1}} << IMM_W);
            default: ext_new = '0;
        endcase
    end

    assign accept    = in_valid & in_ready_q;
    assign deliver   = (state != EMPTY) & out_ready;
    assign out_valid = (state != EMPTY);
    assign in_ready  = in_ready_q;
    assign ext       = or_q;
    assign bad_op    = bad_q;

    always_comb begin
        state_n = state;
        load_or = 1'b0;
        load_sk = 1'b0;
        move_sk = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    state_n = ONE;
                    load_or = 1'b1;
                end
            end
            ONE: begin
                if (accept && !deliver) begin
                    state_n = TWO;
                    load_sk = 1'b1;
                end else if (accept && deliver) begin
                    load_or = 1'b1;
                end else if (deliver) begin
                    state_n = EMPTY;
                end
            end
            TWO: begin
                if (deliver) begin
                    state_n = ONE;
                    move_sk = 1'b1;
                end
            end
            default: state_n = EMPTY;
        endcase
        // Flush drops both buffered entries and any operand offered this cycle.
        if (flush) begin
            state_n = EMPTY;
            load_or = 1'b0;
            load_sk = 1'b0;
            move_sk = 1'b0;
        end
        bad_set = accept & reserved & ~flush;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= EMPTY;
            in_ready_q <= 1'b1;
            or_q       <= '0;
            sk_q       <= '0;
            bad_q      <= 1'b0;
        end else begin
            state      <= state_n;
            in_ready_q <= (state_n != TWO);
            if (load_or)
                or_q <= ext_new;
            else if (move_sk)
                or_q <= sk_q;
            if (load_sk)
                sk_q <= ext_new;
            if (bad_set)
                bad_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ext_pipe.sv
// Self-checking bench for ext_pipe: directed mode vectors, backpressure, flush,
// reserved-op reporting and randomized traffic against a queue-based model.
module tb_ext_pipe;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic [15:0] imm;
    logic [2:0]  eop;
    logic        in_ready, out_valid, bad_op;
    logic [31:0] ext;
    logic        in_ready64, out_valid64, bad_op64;
    logic [63:0] ext64;

    int checks = 0;
    int errors = 0;

    logic [31:0] mq[$];
    logic        m_bad;

    always #5 clk = ~clk;

    ext_pipe #(.IMM_W(16), .DATA_W(32), .SHIFT(2)) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .imm(imm), .EOp(eop), .out_valid(out_valid), .out_ready(out_ready), .ext(ext),
        .bad_op(bad_op)
    );

    ext_pipe #(.IMM_W(16), .DATA_W(64), .SHIFT(2)) dut64 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
        .imm(imm), .EOp(eop), .out_valid(out_valid64), .out_ready(out_ready), .ext(ext64),
        .bad_op(bad_op64)
    );

    function automatic logic [31:0] ref_ext(input logic [15:0] i, input logic [2:0] op);
        longint s, z, r;
        z = longint'(i);
        s = i[15] ? z - 65536 : z;
        case (op)
            3'd0:    r = s;
            3'd1:    r = z;
            3'd2:    r = z * 65536;
            3'd3:    r = s * 4;
            3'd4:    r = z * 4;
            3'd5:    r = z + 64'hFFFF_0000;
            default: r = 0;
        endcase
        return r[31:0];
    endfunction

    // One clock: apply inputs, advance the model, then compare every output.
    task automatic cycle(input logic v, input logic [15:0] i, input logic [2:0] op,
                         input logic ordy, input logic fl, input logic rst);
        logic acc, del;
        in_valid  = v;
        imm       = i;
        eop       = op;
        out_ready = ordy;
        flush     = fl;
        reset     = rst;
        acc = v && (mq.size() < 2);
        del = (mq.size() > 0) && ordy;
        @(posedge clk);
        #1;
        if (rst) begin
            mq.delete();
            m_bad = 1'b0;
        end else if (fl) begin
            mq.delete();
        end else begin
            if (del) void'(mq.pop_front());
            if (acc) begin
                mq.push_back(ref_ext(i, op));
                if (op >= 3'd6) m_bad = 1'b1;
            end
        end
        checks++;
        if (out_valid !== (mq.size() > 0)) begin
            errors++;
            $display("FAIL out_valid got %0b want %0b at %0t", out_valid, mq.size() > 0, $time);
        end
        checks++;
        if (in_ready !== (mq.size() < 2)) begin
            errors++;
            $display("FAIL in_ready got %0b want %0b at %0t", in_ready, mq.size() < 2, $time);
        end
        checks++;
        if (bad_op !== m_bad) begin
            errors++;
            $display("FAIL bad_op got %0b want %0b at %0t", bad_op, m_bad, $time);
        end
        if (mq.size() > 0) begin
            checks++;
            if (ext !== mq[0]) begin
                errors++;
                $display("FAIL ext got %h want %h at %0t", ext, mq[0], $time);
            end
        end
    endtask

    task automatic idle(input logic ordy);
        cycle(1'b0, 16'h0, 3'd0, ordy, 1'b0, 1'b0);
    endtask

    task automatic test_reset;
        cycle(1'b1, 16'h1234, 3'd1, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (ext !== 32'h0 || out_valid !== 1'b0 || in_ready !== 1'b1 || bad_op !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got ext=%h ov=%b ir=%b bad=%b want 0/0/1/0",
                     ext, out_valid, in_ready, bad_op);
        end
    endtask

    task automatic test_modes;
        logic [15:0] vi[7];
        logic [2:0]  vo[7];
        logic [31:0] ve[7];
        vi = '{16'h8000, 16'h1234, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0001, 16'h7FFF};
        vo = '{3'd0, 3'd2, 3'd1, 3'd3, 3'd4, 3'd5, 3'd0};
        ve = '{32'hFFFF8000, 32'h12340000, 32'h0000FFFF, 32'hFFFFFFFC, 32'h0003FFFC,
               32'hFFFF0001, 32'h00007FFF};
        for (int k = 0; k < 7; k++) begin
            cycle(1'b1, vi[k], vo[k], 1'b1, 1'b0, 1'b0);
            checks++;
            if (ext !== ve[k] || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL mode%0d got %h ov=%b want %h", k, ext, out_valid, ve[k]);
            end
        end
        idle(1'b1);
    endtask

    task automatic test_backpressure;
        cycle(1'b1, 16'd1, 3'd1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 16'd2, 3'd1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (in_ready !== 1'b0 || ext !== 32'd1) begin
            errors++;
            $display("FAIL bp_full got ir=%b ext=%h want ir=0 ext=1", in_ready, ext);
        end
        cycle(1'b1, 16'd3, 3'd1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (ext !== 32'd1 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_hold got ext=%h ov=%b want 1/1", ext, out_valid);
        end
        idle(1'b1);
        checks++;
        if (ext !== 32'd2 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_drain got ext=%h ir=%b want 2/1", ext, in_ready);
        end
        idle(1'b1);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_empty got ov=%b want 0", out_valid);
        end
    endtask

    task automatic test_flush;
        cycle(1'b1, 16'hAAAA, 3'd1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 16'hBBBB, 3'd1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 16'hCCCC, 3'd1, 1'b1, 1'b1, 1'b0);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_two got ov=%b ir=%b want 0/1", out_valid, in_ready);
        end
        idle(1'b1);
        idle(1'b1);
        cycle(1'b1, 16'h0011, 3'd1, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 16'h0022, 3'd1, 1'b1, 1'b1, 1'b0);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_acc_del got ov=%b want 0", out_valid);
        end
        idle(1'b1);
    endtask

    task automatic test_bad_op;
        cycle(1'b1, 16'h5555, 3'd6, 1'b0, 1'b0, 1'b0);
        checks++;
        if (ext !== 32'h0 || bad_op !== 1'b1 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bad_set got ext=%h bad=%b ov=%b want 0/1/1", ext, bad_op, out_valid);
        end
        cycle(1'b0, 16'h0, 3'd0, 1'b0, 1'b1, 1'b0);
        idle(1'b1);
        checks++;
        if (bad_op !== 1'b1) begin
            errors++;
            $display("FAIL bad_sticky got %b want 1", bad_op);
        end
        cycle(1'b0, 16'h0, 3'd0, 1'b1, 1'b0, 1'b1);
        checks++;
        if (bad_op !== 1'b0) begin
            errors++;
            $display("FAIL bad_reset got %b want 0", bad_op);
        end
        cycle(1'b1, 16'h1111, 3'd7, 1'b1, 1'b1, 1'b0);
        checks++;
        if (bad_op !== 1'b0) begin
            errors++;
            $display("FAIL bad_flushed got %b want 0", bad_op);
        end
    endtask

    task automatic test_wide;
        cycle(1'b1, 16'hABCD, 3'd2, 1'b1, 1'b0, 1'b0);
        checks++;
        if (ext64 !== 64'hABCD000000000000 || out_valid64 !== 1'b1) begin
            errors++;
            $display("FAIL wide_lui got %h ov=%b want abcd000000000000", ext64, out_valid64);
        end
        cycle(1'b1, 16'hFFFF, 3'd3, 1'b1, 1'b0, 1'b0);
        checks++;
        if (ext64 !== 64'hFFFFFFFFFFFFFFFC) begin
            errors++;
            $display("FAIL wide_sshift got %h want fffffffffffffffc", ext64);
        end
        idle(1'b1);
    endtask

    task automatic test_random;
        for (int n = 0; n < 600; n++) begin
            cycle(($urandom_range(0, 3) != 0), 16'($urandom), 3'($urandom_range(0, 7)),
                  ($urandom_range(0, 2) != 0), ($urandom_range(0, 29) == 0),
                  ($urandom_range(0, 149) == 0));
        end
    endtask

    task automatic test_back_to_back;
        for (int n = 0; n < 40; n++)
            cycle(1'b1, 16'(n * 977), 3'(n % 6), 1'b1, 1'b0, 1'b0);
        for (int n = 0; n < 4; n++)
            idle(1'b1);
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        imm = '0; eop = '0; m_bad = 1'b0;
        test_reset;
        test_modes;
        test_backpressure;
        test_flush;
        test_bad_op;
        test_wide;
        test_back_to_back;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
